// File: rtl/cic_comb_decimator.sv
`default_nettype none
// ============================================================================
// Module   : cic_comb_decimator
// Brief    : CIC comb section with programmable decimation, M=1, and warm-up gating
// Revision : 1.0
// ============================================================================
module cic_comb_decimator #(
    parameter int idw = 9,
    parameter int odw = 9,
    parameter int N   = 3,
    parameter int rw  = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic signed [idw-1:0] data_in,
    input  logic        [rw-1:0]  dec_ratio,
    output logic signed [odw-1:0] data_out,
    output logic                  out_valid
);

    localparam int c_SHIFT  = idw - odw;
    localparam int c_WARM_W = $clog2(N + 1);
    localparam logic [c_WARM_W-1:0] c_WARM_MAX = c_WARM_W'(N);

    logic        [rw-1:0]       cnt_q, cnt_d;
    logic        [c_WARM_W-1:0] warm_q, warm_d;
    logic signed [idw-1:0]      dly_q [N];
    logic signed [idw-1:0]      dly_d [N];
    logic signed [odw-1:0]      data_out_q, data_out_d;
    logic                       valid_q, valid_d;

    logic        [rw-1:0]       w_ratio_m1;
    logic                       w_tick;
    logic signed [idw-1:0]      w_stage [N+1];
    logic signed [odw-1:0]      w_result;

    // Ratios 0 and 1 both collapse to "tick on every enabled clock".
    assign w_ratio_m1 = (dec_ratio <= rw'(1)) ? '0 : (dec_ratio - rw'(1));
    assign w_tick     = en && (cnt_q >= w_ratio_m1);

    assign w_stage[0] = data_in;

    for (genvar k = 0; k < N; k++) begin : g_comb
        assign w_stage[k+1] = w_stage[k] - dly_q[k];
    end

    assign w_result = odw'(w_stage[N] >>> c_SHIFT);

    always_comb begin
        cnt_d      = cnt_q;
        warm_d     = warm_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        for (int k = 0; k < N; k++) begin
            dly_d[k] = dly_q[k];
        end
        if (w_tick) begin
            cnt_d      = '0;
            data_out_d = w_result;
            valid_d    = (warm_q == c_WARM_MAX);
            if (warm_q != c_WARM_MAX) begin
                warm_d = warm_q + c_WARM_W'(1);
            end
            for (int k = 0; k < N; k++) begin
                dly_d[k] = w_stage[k];
            end
        end else if (en) begin
            cnt_d = cnt_q + rw'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            warm_q     <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            for (int k = 0; k < N; k++) begin
                dly_q[k] <= '0;
            end
        end else begin
            cnt_q      <= cnt_d;
            warm_q     <= warm_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            for (int k = 0; k < N; k++) begin
                dly_q[k] <= dly_d[k];
            end
        end
    end

    assign data_out  = data_out_q;
    assign out_valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_cic_comb_decimator.sv
`default_nettype none
// ============================================================================
// Module   : tb_cic_comb_decimator
// Brief    : Bench for three comb configurations sharing one stimulus stream
// Revision : 1.0
// ============================================================================
module tb_cic_comb_decimator;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              en = 1'b0;
    logic signed [8:0] data_in = '0;
    logic        [7:0] dec_ratio = 8'd1;
    logic signed [8:0] dout0, dout1;
    logic signed [5:0] dout2;
    logic              val0, val1, val2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cic_comb_decimator #(.idw(9), .odw(9), .N(3), .rw(8)) d0 (
        .clk(clk), .reset_n(reset_n), .en(en), .data_in(data_in),
        .dec_ratio(dec_ratio), .data_out(dout0), .out_valid(val0));
    cic_comb_decimator #(.idw(9), .odw(9), .N(1), .rw(8)) d1 (
        .clk(clk), .reset_n(reset_n), .en(en), .data_in(data_in),
        .dec_ratio(dec_ratio), .data_out(dout1), .out_valid(val1));
    cic_comb_decimator #(.idw(9), .odw(6), .N(1), .rw(8)) d2 (
        .clk(clk), .reset_n(reset_n), .en(en), .data_in(data_in),
        .dec_ratio(dec_ratio), .data_out(dout2), .out_valid(val2));

    // Reference: the output of an N-stage M=1 comb is the N-th finite difference
    // of the decimated sample sequence, i.e. a binomial-weighted sum, mod 2^9.
    int m_cnt;
    int m_ticks;
    int m_hist [0:8];
    int m_out  [3];
    bit m_val  [3];
    int cfg_n  [3] = '{3, 1, 1};
    int cfg_sh [3] = '{0, 0, 3};

    function automatic int binom(input int n, input int k);
        int r = 1;
        for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
        return r;
    endfunction

    function automatic int ref_out(input int n, input int sh);
        int s = 0;
        for (int j = 0; j <= n; j++) s += (((j % 2) == 1) ? -1 : 1) * binom(n, j) * m_hist[j];
        s = s & 511;
        if (s >= 256) s -= 512;
        return s >>> sh;
    endfunction

    task automatic m_clear();
        m_cnt = 0;
        m_ticks = 0;
        for (int j = 0; j <= 8; j++) m_hist[j] = 0;
        for (int c = 0; c < 3; c++) begin
            m_out[c] = 0;
            m_val[c] = 1'b0;
        end
    endtask

    task automatic step(input bit e, input int din);
        int r;
        en = e;
        data_in = din[8:0];
        @(posedge clk);
        for (int c = 0; c < 3; c++) m_val[c] = 1'b0;
        if (en) begin
            r = (dec_ratio <= 1) ? 1 : int'(dec_ratio);
            if (m_cnt + 1 >= r) begin
                for (int j = 8; j > 0; j--) m_hist[j] = m_hist[j-1];
                m_hist[0] = data_in;
                m_ticks++;
                for (int c = 0; c < 3; c++) begin
                    m_out[c] = ref_out(cfg_n[c], cfg_sh[c]);
                    m_val[c] = (m_ticks > cfg_n[c]);
                end
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        en = 1'b0;
        m_clear();
        @(posedge clk);
        @(posedge clk);
        #3 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (dout0 !== 9'sd0) begin errors++; $display("FAIL reset_dout0 got %0d want 0", dout0); end
        checks++; if (dout2 !== 6'sd0) begin errors++; $display("FAIL reset_dout2 got %0d want 0", dout2); end
        checks++; if ({val0, val1, val2} !== 3'b000) begin errors++; $display("FAIL reset_valid got %b want 000", {val0, val1, val2}); end
    endtask

    task automatic test_step();
        int exp_vals [4] = '{1, -2, 1, 0};
        int idx = 0;
        dec_ratio = 8'd4;
        do_reset();
        for (int i = 1; i <= 28; i++) begin
            step(1'b1, (i > 12) ? 1 : 0);
            checks++;
            if (val0 !== ((i % 4 == 0) && (i >= 16))) begin
                errors++; $display("FAIL step_valid clk %0d got %b", i, val0);
            end
            if ((i % 4 == 0) && (i >= 16)) begin
                checks++;
                if (int'(dout0) != exp_vals[idx]) begin
                    errors++; $display("FAIL step_data clk %0d got %0d want %0d", i, dout0, exp_vals[idx]);
                end
                idx++;
            end
        end
    endtask

    task automatic test_wrap();
        dec_ratio = 8'd1;
        do_reset();
        step(1'b1, 255);
        checks++; if (val1 !== 1'b0) begin errors++; $display("FAIL wrap_warm got %b want 0", val1); end
        step(1'b1, -256);
        checks++; if (val1 !== 1'b1 || int'(dout1) != 1) begin
            errors++; $display("FAIL wrap_data got %0d/%b want 1/1", dout1, val1);
        end
    endtask

    task automatic test_trunc();
        dec_ratio = 8'd0;
        do_reset();
        step(1'b1, 0);
        step(1'b1, -9);
        checks++; if (val2 !== 1'b1 || int'(dout2) != -2) begin
            errors++; $display("FAIL trunc_data got %0d/%b want -2/1", dout2, val2);
        end
    endtask

    task automatic test_ratio_change();
        dec_ratio = 8'd8;
        do_reset();
        for (int i = 0; i < 29; i++) step(1'b1, $urandom_range(0, 511));
        dec_ratio = 8'd3;
        for (int i = 0; i < 9; i++) begin
            step(1'b1, $urandom_range(0, 511));
            checks++;
            if (val0 !== (i % 3 == 0)) begin errors++; $display("FAIL ratio3_valid step %0d got %b", i, val0); end
            if (val0 && int'(dout0) != m_out[0]) begin
                errors++; $display("FAIL ratio3_data got %0d want %0d", dout0, m_out[0]);
            end
        end
        dec_ratio = 8'd0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, $urandom_range(0, 511));
            checks++;
            if (val0 !== 1'b1 || int'(dout0) != m_out[0]) begin
                errors++; $display("FAIL ratio0 got %0d/%b want %0d/1", dout0, val0, m_out[0]);
            end
        end
    endtask

    task automatic test_enable();
        logic signed [8:0] held;
        dec_ratio = 8'd4;
        do_reset();
        for (int i = 0; i < 14; i++) step(1'b1, $urandom_range(0, 511));
        held = dout0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, $urandom_range(0, 511));
            checks++;
            if (val0 !== 1'b0 || dout0 !== held) begin
                errors++; $display("FAIL en_freeze got %0d/%b want %0d/0", dout0, val0, held);
            end
        end
        step(1'b1, $urandom_range(0, 511));
        checks++; if (val0 !== 1'b0) begin errors++; $display("FAIL en_resume1 got %b want 0", val0); end
        step(1'b1, $urandom_range(0, 511));
        checks++; if (val0 !== 1'b1 || int'(dout0) != m_out[0]) begin
            errors++; $display("FAIL en_resume2 got %0d/%b want %0d/1", dout0, val0, m_out[0]);
        end
    endtask

    task automatic test_async_reset();
        bit seen = 1'b0;
        dec_ratio = 8'd4;
        for (int i = 0; i < 60 && !seen; i++) begin
            step(1'b1, $urandom_range(1, 255));
            seen = val0;
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL async_wait got no out_valid within 60 clocks");
        end else begin
            #1 reset_n = 1'b0;
            #1;
            checks++;
            if (val0 !== 1'b0 || dout0 !== 9'sd0) begin
                errors++; $display("FAIL async_reset got %0d/%b want 0/0", dout0, val0);
            end
        end
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, $urandom_range(0, 511));
            checks++;
            if (val0 !== (i == 16) || (val0 && int'(dout0) != m_out[0])) begin
                errors++; $display("FAIL restart clk %0d got %0d/%b want %0d/%b", i, dout0, val0, m_out[0], i == 16);
            end
        end
    endtask

    task automatic test_random();
        int bad = 0;
        dec_ratio = 8'd5;
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 49) == 0) dec_ratio = 8'($urandom_range(0, 6));
            step($urandom_range(0, 3) != 0, $urandom_range(0, 511));
            checks++;
            if (val0 !== m_val[0] || val1 !== m_val[1] || val2 !== m_val[2]
                || int'(dout0) != m_out[0] || int'(dout1) != m_out[1] || int'(dout2) != m_out[2]) begin
                errors++;
                if (bad < 10) $display("FAIL random cyc %0d got %0d/%0d/%0d v%b%b%b want %0d/%0d/%0d v%b%b%b",
                    i, dout0, dout1, dout2, val0, val1, val2,
                    m_out[0], m_out[1], m_out[2], m_val[0], m_val[1], m_val[2]);
                bad++;
            end
        end
    endtask

    initial begin
        m_clear();
        #2;
        test_reset();
        test_step();
        test_wrap();
        test_trunc();
        test_ratio_change();
        test_enable();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cic_comb_decimator.md
CIC_COMB_DECIMATOR -- requirements
Module: cic_comb_decimator

Interface
REQ-001 The block SHALL have parameter idw, default 9: input sample width, matching the integrator chain output width.
REQ-002 The block SHALL have parameter odw, default 9: output sample width, with odw <= idw.
REQ-003 The block SHALL have parameter N, default 3: number of comb stages, 1..8.
REQ-004 The block SHALL have parameter rw, default 8: width of the decimation ratio input.
REQ-005 Port clk, input, 1 bit: single clock; all state SHALL update on its rising edge.
REQ-006 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port en, input, 1 bit: input sample enable; data_in is consumed only when en=1.
REQ-008 Port data_in, input, signed idw bits: integrator output, two's complement.
REQ-009 Port dec_ratio, input, rw bits: decimation ratio R; the values 0 and 1 SHALL both mean R=1.
REQ-010 Port data_out, output, signed odw bits: comb result, registered.
REQ-011 Port out_valid, output, 1 bit: single-cycle strobe marking a new valid data_out.

Function
REQ-012 A decimation counter cnt (rw bits) SHALL advance by 1 on each clock with en=1 and hold when en=0.
REQ-013 A tick SHALL occur on a clock with en=1 and cnt >= max(dec_ratio,1)-1; on a tick, cnt SHALL return to 0.
REQ-014 dec_ratio SHALL be read live; lowering it below the current cnt SHALL cause a tick on the next enabled clock.
REQ-015 The comb chain SHALL be combinational within one tick: stage 0 input = data_in; stage k output = stage k input - dly[k]; stage N-1 output = comb result.
REQ-016 On a tick, each dly[k] SHALL load its stage input; dly[k] SHALL hold on all other clocks (differential delay M=1).
REQ-017 All comb subtractions SHALL be idw-bit modular, wrapping silently on overflow with no saturation.
REQ-018 On a tick, data_out SHALL load the comb result arithmetically shifted right by (idw-odw), i.e. truncation of the LSBs.
REQ-019 Latency: a tick at clock edge T SHALL make data_out and out_valid visible after edge T; out_valid SHALL be high for exactly one cycle per tick.
REQ-020 data_out SHALL hold its value between ticks.
REQ-021 Warm-up: a tick counter (saturating at N) SHALL suppress out_valid for the first N ticks after reset; data_out still updates during warm-up.
REQ-022 With en=0, cnt, dly[], data_out and the warm-up counter SHALL hold, and out_valid SHALL be 0.
REQ-023 When dec_ratio <= 1, every enabled clock SHALL be a tick.

Reset
REQ-024 While reset_n=0, cnt, all dly[k], data_out and the warm-up counter SHALL be 0 and out_valid SHALL be 0, independent of clk.
REQ-025 Assertion of reset_n mid-period SHALL discard the partial period and restart warm-up; the first tick after release SHALL occur on the R-th enabled clock.

Verification
REQ-026 Reset: assert reset_n=0 mid-stream with out_valid high -> data_out=0 and out_valid=0 immediately, without waiting for a clk edge.
REQ-027 Step response (N=3, R=4, en=1): data_in=0 for the first 12 clocks, then 1 -> ticks at clocks 4, 8, 12 produce no out_valid; clocks 16, 20, 24, 28 give out_valid with data_out = 1, -2, 1, 0.
REQ-028 Wrap (N=1, idw=odw=9, R=1): tick samples 255 then -256 -> second output is 1, from the modular difference.
REQ-029 Ratio change (R=8, cnt=5): set dec_ratio=3 -> tick on the next enabled clock, then every 3 enabled clocks; dec_ratio=0 -> out_valid every enabled clock after warm-up.
REQ-030 Enable gating (R=4): drop en for 10 clocks at cnt=2 -> no out_valid and all state frozen; the tick occurs on the 2nd enabled clock after en returns.
REQ-031 Truncation (idw=9, odw=6, N=1, R=1): comb result -9 -> data_out=-2, by arithmetic right shift of 3.
